wb_src_arbiter: RTL and testbench

//  Round-robin arbiter sharing the 16-bit writeback path (7:1 source mux, 3-bit select) among

---
 rtl/wb_arb_pkg.sv | 27 ++
 rtl/wb_rr_pick.sv | 32 +++
 rtl/wb_src_arbiter.sv | 130 +++++++++++++
 tb/tb_wb_src_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared constants, FSM state type and helpers for the writeback-source arbiter.
// The WB_ARB_TIMEOUT_EN build uses MAX_HOLD/HOLD_W/HOLD_MAX for owner preemption.
package wb_arb_pkg;

    localparam int NUM_REQ  = 7;
    localparam int SEL_W    = 3;
    localparam int MAX_HOLD = 8;
    localparam int HOLD_W   = $clog2(MAX_HOLD);

    localparam logic [SEL_W-1:0]  SEL_IDLE = '0;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = idx | SEL_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from ptr+1,
// wrapping modulo NUM_REQ, so the source at ptr itself is considered last.
module wb_rr_pick
    import wb_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               any_req
);

    logic [SEL_W-1:0] pos;
    logic             found;

    // NOTE: every variable written here gets a default first, otherwise the
    // paths that skip an assignment would infer a latch.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        pos    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            pos = SEL_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[pos]) begin
                winner[pos] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/wb_src_arbiter.sv
// Round-robin owner arbiter for the 7:1 writeback source mux (one-hot grant + select).
// Define WB_ARB_TIMEOUT_EN to preempt an owner after MAX_HOLD cycles when others wait.
module wb_src_arbiter
    import wb_arb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic               bus_valid,
    output logic               preempt
);

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;

    logic [NUM_REQ-1:0] pick_req;
    logic [SEL_W-1:0]   pick_ptr;
    logic [NUM_REQ-1:0] winner;
    logic               any_req;
    logic               owner_req;

`ifdef WB_ARB_TIMEOUT_EN
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               preempt_q, preempt_d;
`endif

    // The owner is masked out and the scan starts after it, so a release or a
    // preemption can never hand the path straight back to the same source.
    assign pick_req  = req & ~grant_q;
    assign pick_ptr  = (state_q == OWN) ? sel_q : ptr_q;
    assign owner_req = |(req & grant_q);

    wb_rr_pick u_pick (
        .req     (pick_req),
        .ptr     (pick_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
`ifdef WB_ARB_TIMEOUT_EN
        hold_d    = hold_q;
        preempt_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = OWN;
                    grant_d = winner;
                    sel_d   = onehot_to_idx(winner);
                end
            end
            OWN: begin
                if (!owner_req) begin
                    ptr_d = sel_q;
                    if (any_req) begin
                        grant_d = winner;
                        sel_d   = onehot_to_idx(winner);
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        sel_d   = SEL_IDLE;
                    end
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (hold_q == HOLD_MAX) begin
                    // Saturated: give way only if someone else is waiting.
                    if (any_req) begin
                        ptr_d     = sel_q;
                        grant_d   = winner;
                        sel_d     = onehot_to_idx(winner);
                        preempt_d = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
`ifdef WB_ARB_TIMEOUT_EN
        if (grant_d != grant_q) hold_d = '0;
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= SEL_IDLE;
            ptr_q   <= SEL_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    assign preempt = preempt_q;
`else
    assign preempt = 1'b0;
`endif

    assign grant     = grant_q;
    assign sel       = sel_q;
    assign bus_valid = |grant_q;

endmodule

// File: tb/tb_wb_src_arbiter.sv
// Self-checking bench for wb_src_arbiter: vector table plus hand-written sequences,
// with expected outputs queued at drive time and compared one edge later.
module tb_wb_src_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] req;
    logic [6:0] grant;
    logic [2:0] sel;
    logic       bus_valid;
    logic       preempt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [6:0] grant;
        logic [2:0] sel;
        logic       valid;
        logic       preempt;
    } obs_t;

    typedef struct {
        logic  rst;
        logic [6:0] req;
        obs_t  exp;
        string name;
    } vec_t;

    obs_t  exp_q[$];
    string name_q[$];
    vec_t  tbl[$];

    wb_src_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .grant     (grant),
        .sel       (sel),
        .bus_valid (bus_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    function automatic obs_t mk(input logic [6:0] g, input logic [2:0] s, input logic p);
        obs_t o;
        o.grant   = g;
        o.sel     = s;
        o.valid   = (g != 7'h00);
        o.preempt = p;
        return o;
    endfunction

    function automatic void add(input logic r, input logic [6:0] rq, input logic [6:0] g,
                                input logic [2:0] s, input string n);
        vec_t v;
        v.rst  = r;
        v.req  = rq;
        v.exp  = mk(g, s, 1'b0);
        v.name = n;
        tbl.push_back(v);
    endfunction

    task automatic check(input string n, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got grant=%h sel=%0d valid=%b preempt=%b, want grant=%h sel=%0d valid=%b preempt=%b",
                     n, act.grant, act.sel, act.valid, act.preempt,
                     exp.grant, exp.sel, exp.valid, exp.preempt);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic step(input logic r, input logic [6:0] rq, input obs_t e, input string n);
        obs_t act;
        obs_t exp;
        string nm;
        reset = r;
        req   = rq;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
        act = '{grant: grant, sel: sel, valid: bus_valid, preempt: preempt};
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got output with no expectation queued");
        end else begin
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            check(nm, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = 7'h00;

        // Reset with all requests high, then first grant to source 0.
        add(1, 7'h7F, 7'h00, 0, "rst_hold1");
        add(1, 7'h7F, 7'h00, 0, "rst_hold2");
        add(0, 7'h7F, 7'h01, 0, "first_grant_src0");
        add(0, 7'h00, 7'h00, 0, "src0_release_idle");
        // Lone source 4: one-cycle latency, held, released.
        add(0, 7'h10, 7'h10, 4, "src4_grant");
        add(0, 7'h10, 7'h10, 4, "src4_hold1");
        add(0, 7'h10, 7'h10, 4, "src4_hold2");
        add(0, 7'h00, 7'h00, 0, "src4_release");
        // Source 2 owns; 5 and 1 arrive; RR from pointer 2 gives 5 then 1.
        add(1, 7'h00, 7'h00, 0, "rst_rr");
        add(0, 7'h04, 7'h04, 2, "src2_grant");
        add(0, 7'h26, 7'h04, 2, "src2_hold_with_pending");
        add(0, 7'h22, 7'h20, 5, "switch_to_src5");
        add(0, 7'h02, 7'h02, 1, "switch_to_src1");
        add(0, 7'h00, 7'h00, 0, "rr_idle");
        // Reset while source 3 owns, pending req re-granted afterwards.
        add(0, 7'h08, 7'h08, 3, "src3_grant");
        add(1, 7'h08, 7'h00, 0, "rst_mid_grant");
        add(0, 7'h08, 7'h08, 3, "src3_regrant");
        add(0, 7'h00, 7'h00, 0, "src3_release");
        // Source 1 withdraws before being served: never selected.
        add(1, 7'h00, 7'h00, 0, "rst_withdraw");
        add(0, 7'h03, 7'h01, 0, "src0_wins_over_src1");
        add(0, 7'h00, 7'h00, 0, "src1_withdrew_idle");

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].exp, tbl[i].name);
        end

        // All sources requesting, each owner drops for one cycle after two
        // grant cycles: select walks 0..6 then back to 0 with no idle gap.
        step(1, 7'h00, mk(7'h00, 0, 0), "rst_walk");
        step(0, 7'h7F, mk(7'h01, 0, 0), "walk_start");
        for (int k = 0; k < 7; k++) begin
            logic [6:0] own;
            logic [6:0] nxt;
            own = 7'h01 << k;
            nxt = 7'h01 << ((k + 1) % 7);
            step(0, 7'h7F, mk(own, 3'(k), 0), $sformatf("walk_hold_%0d", k));
            step(0, 7'h7F & ~own, mk(nxt, 3'((k + 1) % 7), 0), $sformatf("walk_next_%0d", k));
        end

        // Source 0 hogs the path while source 6 waits.
        step(1, 7'h00, mk(7'h00, 0, 0), "rst_hog");
        step(0, 7'h41, mk(7'h01, 0, 0), "hog_grant");
        for (int i = 1; i < 8; i++) begin
            step(0, 7'h41, mk(7'h01, 0, 0), $sformatf("hog_hold_%0d", i));
        end
        if (TIMEOUT) begin
            step(0, 7'h41, mk(7'h40, 6, 1), "hog_preempted");
            step(0, 7'h41, mk(7'h40, 6, 0), "preempt_one_pulse");
        end else begin
            step(0, 7'h41, mk(7'h01, 0, 0), "hog_kept");
            step(0, 7'h41, mk(7'h01, 0, 0), "hog_kept_more");
        end

        // Lone owner past the hold limit keeps the path; a late rival then
        // preempts immediately because the hold count has saturated.
        step(1, 7'h00, mk(7'h00, 0, 0), "rst_sat");
        step(0, 7'h01, mk(7'h01, 0, 0), "sat_grant");
        for (int i = 0; i < 12; i++) begin
            step(0, 7'h01, mk(7'h01, 0, 0), $sformatf("sat_hold_%0d", i));
        end
        if (TIMEOUT) begin
            step(0, 7'h41, mk(7'h40, 6, 1), "sat_preempt");
        end else begin
            step(0, 7'h41, mk(7'h01, 0, 0), "sat_no_preempt");
        end

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover, want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
